port_rd_sink: RTL and testbench
===============================

Name: port_rd_sink

Overview:
- Per-port consumer for the switch read interface (ready / rd_sop / rd_vld / rd_data / rd_eop).
- It is the read-side counterpart of the write-side packet source. It requests one packet at a time with a ready pulse, then parses and checks the packet: header, destination, length and payload.
- It keeps saturating packet and error counters for system-level checking.
- One instance sits on each of the 16 output ports.

Parameters:
- PORT_ID, 0, this instance's output port number (0-15); compared with header bits [3:0].
- READY_GAP, 16, idle cycles from end of packet (or reset release) to the next ready pulse; 0 is legal.
- SOP_TIMEOUT, 4095, cycles allowed in WAIT_SOP before the timeout flag sets; 0 disables the timeout.
- CHECK_PAYLOAD, 1, when 1 the payload word k (k=1..len) must equal k.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  permits new ready requests; a packet already in flight always completes
- clear  in  1  synchronous clear of all counters and sticky flags; the FSM is unaffected
- ready  out  1  one-cycle request for the next packet
- rd_sop  in  1  packet start pulse
- rd_vld  in  1  data word valid
- rd_data  in  16  header word, then payload words
- rd_eop  in  1  packet end pulse
- busy  out  1  high in WAIT_SOP, WAIT_HDR and DATA
- pkt_cnt  out  16  packets completed without error
- err_len_cnt  out  16  packets whose length does not match the header
- err_dst_cnt  out  16  packets whose header destination does not equal PORT_ID
- err_data_cnt  out  16  packets with at least one payload mismatch
- err_proto_cnt  out  16  protocol violations
- last_prio  out  3  header bits [6:4] of the most recent header
- last_len  out  9  header bits [15:7] of the most recent header
- timeout  out  1  sticky; set on SOP timeout

Behaviour:
- Reset values: all outputs 0. FSM in GAP with the gap counter at 0.
- Header format:
  - [15:7] length = number of payload words
  - [6:4] priority
  - [3:0] destination port
- FSM transitions:
  - GAP: count READY_GAP cycles, then go to IDLE. With READY_GAP=0, go to IDLE the next cycle.
  - IDLE: when enable=1, drive ready=1 for exactly one cycle and go to WAIT_SOP. While enable=0, stay in IDLE.
  - WAIT_SOP: on rd_sop go to WAIT_HDR and clear the payload count and per-packet flags. The timeout counter runs here. When it reaches SOP_TIMEOUT, set timeout (sticky) and stay in WAIT_SOP.
  - WAIT_HDR: the first rd_vld latches last_len and last_prio and checks the destination, then go to DATA. An rd_vld in the same cycle as rd_sop is the header.
  - DATA: each rd_vld increments the 10-bit payload count (saturates at 1023). With CHECK_PAYLOAD=1, rd_data != payload index sets the per-packet data flag.
  - DATA, on rd_eop: if rd_vld is high in the same cycle, that word is counted first. Then evaluate the packet and go to GAP.
- Packet evaluation at rd_eop:
  - Length error: count != last_len → err_len_cnt +1.
  - Destination error: flag set → err_dst_cnt +1.
  - Data error: flag set → err_data_cnt +1.
  - A packet can raise several errors at once, each counter +1.
  - pkt_cnt +1 only when no error flag is set.
- Protocol violations (each err_proto_cnt +1):
  - rd_sop in WAIT_HDR or DATA: discard the current packet without evaluation and restart at WAIT_HDR.
  - rd_vld or rd_eop in GAP, IDLE or WAIT_SOP: ignored.
  - rd_eop in WAIT_HDR: go to GAP, no evaluation.
  - Two ready pulses without an intervening eop cannot occur by construction.
- Counters: all 16-bit and saturating at 0xFFFF. When clear and an increment occur in the same cycle, clear wins.
- Latency: ready is asserted READY_GAP+1 cycles after the rd_eop cycle. Counters update on the clock edge that samples rd_eop.
- Reset mid-packet: asynchronously return to the reset state; no counter increments for the partial packet.

Test Plan:
- Basic packet, PORT_ID=3, READY_GAP=16:
  - Stimulus: after ready, sop; header 0x0F83 (len 31, prio 0, dst 3); payload 1..31; eop.
  - Required: pkt_cnt=1, all error counters 0, last_len=31, next ready exactly 17 cycles after eop.
- Error mix, PORT_ID=3:
  - Stimulus: header length 40 with 39 words sent; then a packet to dst 5; then a packet with word 7 = 0x0000.
  - Required: err_len_cnt=1, err_dst_cnt=1, err_data_cnt=1, pkt_cnt=0.
- Protocol violations:
  - Stimulus: rd_vld in IDLE; rd_sop at payload word 10 followed by a clean 31-word packet; rd_eop directly after sop.
  - Required: err_proto_cnt=3, pkt_cnt=1.
- Flow control and timeout:
  - Stimulus: enable=0 for 100 cycles, then 1. Separately, SOP_TIMEOUT=50 with no sop.
  - Required: no ready while enable=0, one ready after enable rises; timeout=1 on cycle 50 of WAIT_SOP and stays set until clear.
- Edge cases:
  - Stimulus: eop coincident with the last vld; header vld in the same cycle as sop; len=0 packet; 70000 clean packets; clear pulsed together with an eop.
  - Required: all error-free, pkt_cnt saturates at 0xFFFF, clear produces 0 on all counters.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 at payload word 5.
  - Required: all outputs 0 immediately, next ready READY_GAP+1 cycles after reset release.

Source files
------------

// File: rtl/port_rd_sink_if.sv
`timescale 1ns/1ps
// Switch read-port bundle: the sink pulses ready and the switch returns one packet.
interface port_rd_sink_if;
  logic        ready;
  logic        rd_sop;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic        rd_eop;

  // Switch side drives the packet and receives the request.
  modport master (input ready, output rd_sop, output rd_vld, output rd_data, output rd_eop);
  modport slave (output ready, input rd_sop, input rd_vld, input rd_data, input rd_eop);
endinterface

// File: rtl/port_rd_sink.sv
`timescale 1ns/1ps
// Per-port read-side consumer: requests one packet at a time, checks header, destination,
// length and payload, and keeps saturating packet/error counters.
module port_rd_sink #(
  parameter int unsigned PORT_ID       = 0,
  parameter int unsigned READY_GAP     = 16,
  parameter int unsigned SOP_TIMEOUT   = 4095,
  parameter int unsigned CHECK_PAYLOAD = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clear,
  port_rd_sink_if.slave rd,
  output logic          busy,
  output logic [15:0]   pkt_cnt,
  output logic [15:0]   err_len_cnt,
  output logic [15:0]   err_dst_cnt,
  output logic [15:0]   err_data_cnt,
  output logic [15:0]   err_proto_cnt,
  output logic [2:0]    last_prio,
  output logic [8:0]    last_len,
  output logic          timeout
);

  localparam logic [15:0] GapMax = 16'(READY_GAP);
  localparam logic [15:0] ToMax  = 16'(SOP_TIMEOUT);
  localparam logic [3:0]  DstId  = 4'(PORT_ID);

  typedef enum logic [2:0] {StGap, StIdle, StWaitSop, StWaitHdr, StData} state_e;

  state_e      state_q, state_d;
  logic [15:0] gap_q, gap_d, to_cnt_q, to_cnt_d;
  logic [9:0]  pay_q, pay_d, pay_sat;
  logic        dst_err_q, dst_err_d, data_err_q, data_err_d;
  logic [8:0]  len_q, len_d;
  logic [2:0]  prio_q, prio_d;
  logic        timeout_q;
  logic [15:0] pkt_q, len_err_q, dst_cnt_q, data_cnt_q, proto_q;
  logic        rdy, start_pkt, take_hdr, set_to, word_bad;
  logic        inc_pkt, inc_len, inc_dst, inc_data, inc_proto;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pay_sat  = (pay_q == 10'h3FF) ? pay_q : pay_q + 10'd1;
  assign word_bad = (CHECK_PAYLOAD != 0) && (rd.rd_data != {6'd0, pay_sat});

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    to_cnt_d   = to_cnt_q;
    pay_d      = pay_q;
    dst_err_d  = dst_err_q;
    data_err_d = data_err_q;
    len_d      = len_q;
    prio_d     = prio_q;
    rdy        = 1'b0;
    start_pkt  = 1'b0;
    take_hdr   = 1'b0;
    set_to     = 1'b0;
    inc_pkt    = 1'b0;
    inc_len    = 1'b0;
    inc_dst    = 1'b0;
    inc_data   = 1'b0;
    inc_proto  = 1'b0;
    unique case (state_q)
      StGap: begin
        inc_proto = rd.rd_vld | rd.rd_eop;
        if (gap_q >= GapMax) state_d = StIdle;
        else                 gap_d   = gap_q + 16'd1;
      end
      StIdle: begin
        inc_proto = rd.rd_vld | rd.rd_eop;
        if (enable) begin
          rdy      = 1'b1;
          state_d  = StWaitSop;
          // to_cnt holds the number of the current WAIT_SOP cycle, starting at 1
          to_cnt_d = 16'd1;
          set_to   = (ToMax == 16'd1);
        end
      end
      StWaitSop: begin
        if (rd.rd_sop) begin
          start_pkt = 1'b1;
        end else begin
          inc_proto = rd.rd_vld | rd.rd_eop;
          if (to_cnt_q < ToMax) begin
            to_cnt_d = to_cnt_q + 16'd1;
            set_to   = (to_cnt_d == ToMax);
          end
        end
      end
      StWaitHdr: begin
        if (rd.rd_sop) begin
          inc_proto = 1'b1;
          start_pkt = 1'b1;
        end else if (rd.rd_eop) begin
          inc_proto = 1'b1;
          state_d   = StGap;
          gap_d     = 16'd1;
        end else if (rd.rd_vld) begin
          take_hdr = 1'b1;
        end
      end
      StData: begin
        if (rd.rd_sop) begin
          inc_proto = 1'b1;
          start_pkt = 1'b1;
        end else begin
          if (rd.rd_vld) begin
            pay_d = pay_sat;
            if (word_bad) data_err_d = 1'b1;
          end
          if (rd.rd_eop) begin
            inc_len  = ({1'b0, len_q} != pay_d);
            inc_dst  = dst_err_q;
            inc_data = data_err_d;
            inc_pkt  = !(inc_len | inc_dst | inc_data);
            state_d  = StGap;
            // The eop cycle counts as the first gap cycle
            gap_d    = 16'd1;
          end
        end
      end
      default: state_d = StGap;
    endcase
    if (start_pkt) begin
      pay_d      = '0;
      dst_err_d  = 1'b0;
      data_err_d = 1'b0;
      state_d    = StWaitHdr;
      take_hdr   = rd.rd_vld;
    end
    if (take_hdr) begin
      len_d     = rd.rd_data[15:7];
      prio_d    = rd.rd_data[6:4];
      dst_err_d = (rd.rd_data[3:0] != DstId);
      state_d   = StData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StGap;
      gap_q      <= '0;
      to_cnt_q   <= '0;
      pay_q      <= '0;
      dst_err_q  <= 1'b0;
      data_err_q <= 1'b0;
      len_q      <= '0;
      prio_q     <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      to_cnt_q   <= to_cnt_d;
      pay_q      <= pay_d;
      dst_err_q  <= dst_err_d;
      data_err_q <= data_err_d;
      len_q      <= len_d;
      prio_q     <= prio_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q      <= '0;
      len_err_q  <= '0;
      dst_cnt_q  <= '0;
      data_cnt_q <= '0;
      proto_q    <= '0;
      timeout_q  <= 1'b0;
    end else if (clear) begin
      pkt_q      <= '0;
      len_err_q  <= '0;
      dst_cnt_q  <= '0;
      data_cnt_q <= '0;
      proto_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (inc_pkt)   pkt_q      <= sat_inc(pkt_q);
      if (inc_len)   len_err_q  <= sat_inc(len_err_q);
      if (inc_dst)   dst_cnt_q  <= sat_inc(dst_cnt_q);
      if (inc_data)  data_cnt_q <= sat_inc(data_cnt_q);
      if (inc_proto) proto_q    <= sat_inc(proto_q);
      if (set_to)    timeout_q  <= 1'b1;
    end
  end

  assign rd.ready      = rdy;
  assign busy          = (state_q == StWaitSop) || (state_q == StWaitHdr) || (state_q == StData);
  assign pkt_cnt       = pkt_q;
  assign err_len_cnt   = len_err_q;
  assign err_dst_cnt   = dst_cnt_q;
  assign err_data_cnt  = data_cnt_q;
  assign err_proto_cnt = proto_q;
  assign last_prio     = prio_q;
  assign last_len      = len_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_port_rd_sink.sv
`timescale 1ns/1ps
// Bench for port_rd_sink: instance a (PORT_ID 3, gap 16) carries the packet scenarios,
// instance b (gap 0, SOP timeout 50) covers timeout and counter saturation.
module tb_port_rd_sink;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en_a, clr_a, en_b, clr_b;
  port_rd_sink_if ifa ();
  port_rd_sink_if ifb ();

  logic        busy_a, to_a, busy_b, to_b;
  logic [15:0] pkt_a, lerr_a, derr_a, xerr_a, perr_a;
  logic [15:0] pkt_b, lerr_b, derr_b, xerr_b, perr_b;
  logic [2:0]  prio_a, prio_b;
  logic [8:0]  llen_a, llen_b;

  port_rd_sink #(.PORT_ID(3), .READY_GAP(16), .SOP_TIMEOUT(4095), .CHECK_PAYLOAD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .clear(clr_a), .rd(ifa), .busy(busy_a),
    .pkt_cnt(pkt_a), .err_len_cnt(lerr_a), .err_dst_cnt(derr_a), .err_data_cnt(xerr_a),
    .err_proto_cnt(perr_a), .last_prio(prio_a), .last_len(llen_a), .timeout(to_a)
  );

  port_rd_sink #(.PORT_ID(0), .READY_GAP(0), .SOP_TIMEOUT(50), .CHECK_PAYLOAD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .clear(clr_b), .rd(ifb), .busy(busy_b),
    .pkt_cnt(pkt_b), .err_len_cnt(lerr_b), .err_dst_cnt(derr_b), .err_data_cnt(xerr_b),
    .err_proto_cnt(perr_b), .last_prio(prio_b), .last_len(llen_b), .timeout(to_b)
  );

  int checks = 0;
  int failures = 0;
  int m_pkt, m_len, m_dst, m_data, m_proto;
  logic [79:0] sb_q[$];
  logic [79:0] got, exp_v;

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  function automatic logic [79:0] pack_m();
    return {16'(m_pkt), 16'(m_len), 16'(m_dst), 16'(m_data), 16'(m_proto)};
  endfunction

  function automatic logic [94:0] all_a();
    return {ifa.ready, busy_a, pkt_a, lerr_a, derr_a, xerr_a, perr_a, prio_a, llen_a, to_a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle_a();
    ifa.rd_sop = 1'b0; ifa.rd_vld = 1'b0; ifa.rd_eop = 1'b0; ifa.rd_data = '0;
  endtask

  task automatic zero_model();
    m_pkt = 0; m_len = 0; m_dst = 0; m_data = 0; m_proto = 0;
  endtask

  task automatic wait_ready_a(input int limit, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < limit) begin
      if (ifa.ready) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  // Drives sop onward from the current cycle; returns in the cycle after eop is sampled.
  task automatic drive_body(input logic [15:0] hdr, input int nw, input int bad,
                            input bit sop_hdr, input bit eop_last, input bit clr_eop);
    bit lerr, derr, xerr;
    ifa.rd_sop = 1'b1; ifa.rd_vld = sop_hdr; ifa.rd_data = hdr; ifa.rd_eop = 1'b0;
    if (!sop_hdr) begin
      tick();
      ifa.rd_sop = 1'b0; ifa.rd_vld = 1'b1; ifa.rd_data = hdr;
    end
    for (int k = 1; k <= nw; k++) begin
      tick();
      ifa.rd_sop = 1'b0; ifa.rd_vld = 1'b1;
      ifa.rd_data = (k == bad) ? 16'h0000 : 16'(k);
      ifa.rd_eop = eop_last && (k == nw);
    end
    if (!(eop_last && nw > 0)) begin
      tick();
      ifa.rd_sop = 1'b0; ifa.rd_vld = 1'b0; ifa.rd_eop = 1'b1;
    end
    clr_a = clr_eop;
    lerr = (int'(hdr[15:7]) != nw);
    derr = (hdr[3:0] != 4'd3);
    xerr = (bad >= 1) && (bad <= nw);
    if (clr_eop) begin
      zero_model();
    end else begin
      if (lerr) m_len = sat(m_len);
      if (derr) m_dst = sat(m_dst);
      if (xerr) m_data = sat(m_data);
      if (!(lerr || derr || xerr)) m_pkt = sat(m_pkt);
    end
    sb_q.push_back(pack_m());
    tick();
    bus_idle_a();
    clr_a = 1'b0;
  endtask

  task automatic send_a(input logic [15:0] hdr, input int nw, input int bad,
                        input bit sop_hdr, input bit eop_last, input bit clr_eop);
    int n;
    bit ok;
    wait_ready_a(200, n, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_ready: no ready within %0d cycles, required one", n);
    end
    tick();
    drive_body(hdr, nw, bad, sop_hdr, eop_last, clr_eop);
  endtask

  task automatic test_reset();
    int n;
    bit ok;
    rst_n = 1'b0; en_a = 1'b1; clr_a = 1'b0; en_b = 1'b0; clr_b = 1'b0;
    bus_idle_a();
    ifb.rd_sop = 1'b0; ifb.rd_vld = 1'b0; ifb.rd_eop = 1'b0; ifb.rd_data = '0;
    zero_model();
    repeat (3) tick();
    checks++;
    if (all_a() !== 95'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", all_a());
    end
    rst_n = 1'b1;
    wait_ready_a(100, n, ok);
    checks++;
    if (!ok || n != 17) begin
      failures++;
      $display("FAIL reset_ready_latency: got %0d (ok=%0d) required 17", n, ok);
    end
  endtask

  task automatic test_basic();
    int n;
    bit ok;
    tick();
    drive_body(16'h0F83, 31, 0, 1'b0, 1'b0, 1'b0);
    got = {pkt_a, lerr_a, derr_a, xerr_a, perr_a};
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL basic_counters: got %h required %h", got, exp_v);
    end
    checks++;
    if (llen_a !== 9'd31 || prio_a !== 3'd0) begin
      failures++;
      $display("FAIL basic_header: got len %0d prio %0d required 31 0", llen_a, prio_a);
    end
    wait_ready_a(100, n, ok);
    checks++;
    if (!ok || n + 1 != 17) begin
      failures++;
      $display("FAIL basic_ready_latency: got %0d required 17", n + 1);
    end
  endtask

  task automatic test_errors();
    int n;
    bit ok;
    wait_ready_a(100, n, ok);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    zero_model();
    checks++;
    if ({pkt_a, lerr_a, derr_a, xerr_a, perr_a} !== 80'd0) begin
      failures++;
      $display("FAIL errors_clear: got %h required 0", {pkt_a, lerr_a, derr_a, xerr_a, perr_a});
    end
    drive_body(16'h1403, 39, 0, 1'b0, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if ({pkt_a, lerr_a, derr_a, xerr_a, perr_a} !== exp_v) begin
      failures++;
      $display("FAIL err_len: got %h required %h", {pkt_a, lerr_a, derr_a, xerr_a, perr_a}, exp_v);
    end
    send_a(16'h0F85, 31, 0, 1'b0, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if ({pkt_a, lerr_a, derr_a, xerr_a, perr_a} !== exp_v) begin
      failures++;
      $display("FAIL err_dst: got %h required %h", {pkt_a, lerr_a, derr_a, xerr_a, perr_a}, exp_v);
    end
    send_a(16'h0F83, 31, 7, 1'b0, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if ({pkt_a, lerr_a, derr_a, xerr_a, perr_a} !== exp_v) begin
      failures++;
      $display("FAIL err_data: got %h required %h", {pkt_a, lerr_a, derr_a, xerr_a, perr_a}, exp_v);
    end
  endtask

  task automatic test_proto();
    int n;
    bit ok;
    en_a = 1'b0;
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    zero_model();
    repeat (30) tick();
    ifa.rd_vld = 1'b1;
    tick();
    ifa.rd_vld = 1'b0;
    m_proto++;
    en_a = 1'b1;
    wait_ready_a(50, n, ok);
    tick();
    ifa.rd_sop = 1'b1; ifa.rd_vld = 1'b1; ifa.rd_data = 16'h0F83;
    for (int k = 1; k <= 9; k++) begin
      tick();
      ifa.rd_sop = 1'b0; ifa.rd_vld = 1'b1; ifa.rd_data = 16'(k);
    end
    tick();
    m_proto++;
    drive_body(16'h0F83, 31, 0, 1'b0, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if ({pkt_a, lerr_a, derr_a, xerr_a, perr_a} !== exp_v) begin
      failures++;
      $display("FAIL proto_restart: got %h required %h", {pkt_a, lerr_a, derr_a, xerr_a, perr_a}, exp_v);
    end
    wait_ready_a(100, n, ok);
    tick();
    ifa.rd_sop = 1'b1;
    tick();
    ifa.rd_sop = 1'b0; ifa.rd_eop = 1'b1;
    m_proto++;
    sb_q.push_back(pack_m());
    tick();
    bus_idle_a();
    exp_v = sb_q.pop_front();
    checks++;
    if ({pkt_a, lerr_a, derr_a, xerr_a, perr_a} !== exp_v) begin
      failures++;
      $display("FAIL proto_hdr_eop: got %h required %h", {pkt_a, lerr_a, derr_a, xerr_a, perr_a}, exp_v);
    end
  endtask

  task automatic test_flow();
    int cnt;
    en_a = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifa.ready) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL flow_disabled: got %0d ready pulses required 0", cnt);
    end
    en_a = 1'b1;
    #1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifa.ready) cnt++;
      tick();
    end
    checks++;
    if (cnt != 1 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL flow_enabled: got %0d pulses busy %0b required 1 1", cnt, busy_a);
    end
    drive_body(16'h0003, 0, 0, 1'b0, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if ({pkt_a, lerr_a, derr_a, xerr_a, perr_a} !== exp_v) begin
      failures++;
      $display("FAIL flow_len0: got %h required %h", {pkt_a, lerr_a, derr_a, xerr_a, perr_a}, exp_v);
    end
  endtask

  task automatic test_edges();
    logic [15:0] hdrs[4] = '{16'h0F83, 16'h0283, 16'h0003, 16'h0F83};
    int          lens[4] = '{31, 5, 0, 31};
    bit          sh[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit          el[4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
    bit          ce[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    zero_model();
    for (int i = 0; i < 4; i++) begin
      send_a(hdrs[i], lens[i], 0, sh[i], el[i], ce[i]);
      exp_v = sb_q.pop_front();
      checks++;
      if ({pkt_a, lerr_a, derr_a, xerr_a, perr_a} !== exp_v) begin
        failures++;
        $display("FAIL edge_%0d: got %h required %h", i, {pkt_a, lerr_a, derr_a, xerr_a, perr_a},
                 exp_v);
      end
    end
    checks++;
    if (llen_a !== 9'd31) begin
      failures++;
      $display("FAIL edge_last_len: got %0d required 31", llen_a);
    end
  endtask

  task automatic test_timeout();
    int n;
    en_b = 1'b1;
    #1;
    n = 0;
    while (!ifb.ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!ifb.ready) begin
      failures++;
      $display("FAIL timeout_ready: got no ready required one");
    end
    repeat (49) tick();
    checks++;
    if (to_b !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got %0b at cycle 49 required 0", to_b);
    end
    tick();
    checks++;
    if (to_b !== 1'b1) begin
      failures++;
      $display("FAIL timeout_set: got %0b at cycle 50 required 1", to_b);
    end
    repeat (20) tick();
    checks++;
    if (to_b !== 1'b1 || busy_b !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: got to %0b busy %0b required 1 1", to_b, busy_b);
    end
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    repeat (5) tick();
    checks++;
    if (to_b !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: got %0b required 0", to_b);
    end
  endtask

  task automatic test_saturate();
    int expp = 0;
    ifb.rd_vld = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      tick();
      expp = sat(expp);
    end
    checks++;
    if (perr_b !== 16'(expp)) begin
      failures++;
      $display("FAIL sat_proto: got %h required %h", perr_b, 16'(expp));
    end
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    ifb.rd_vld = 1'b0;
    checks++;
    if ({pkt_b, lerr_b, derr_b, xerr_b, perr_b, to_b} !== 81'd0) begin
      failures++;
      $display("FAIL sat_clear: got %h required 0", {pkt_b, lerr_b, derr_b, xerr_b, perr_b});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    wait_ready_a(100, n, ok);
    tick();
    ifa.rd_sop = 1'b1; ifa.rd_vld = 1'b1; ifa.rd_data = 16'h0F83;
    for (int k = 1; k <= 5; k++) begin
      tick();
      ifa.rd_sop = 1'b0; ifa.rd_vld = 1'b1; ifa.rd_data = 16'(k);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (all_a() !== 95'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h required 0", all_a());
    end
    bus_idle_a();
    tick();
    rst_n = 1'b1;
    wait_ready_a(100, n, ok);
    checks++;
    if (!ok || n != 17) begin
      failures++;
      $display("FAIL reset_mid_ready: got %0d (ok=%0d) required 17", n, ok);
    end
    checks++;
    if ({pkt_a, lerr_a, derr_a, xerr_a, perr_a} !== 80'd0) begin
      failures++;
      $display("FAIL reset_mid_counters: got %h required 0", {pkt_a, lerr_a, derr_a, xerr_a, perr_a});
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_proto();
    test_flow();
    test_edges();
    test_timeout();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
